// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared definitions for the systolic array sequencer: state encoding and
// index-width helper used by the controller and its skew generator.
package systolic_seq_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CLEAR = 3'd1;
  localparam state_t ST_FEED  = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_READ  = 3'd4;

  function automatic int idx_bits(input int dim);
    return (dim < 2) ? 1 : $clog2(dim);
  endfunction

endpackage

// File: rtl/systolic_skew_gen.sv
// Combinational operand skew: for feed step t, lane r carries k-index t-r
// while r <= t < r+DIMENSION, and is invalid (index 0) otherwise.
module systolic_skew_gen
  import systolic_seq_ctrl_pkg::*;
#(
  parameter int DIMENSION = 4,
  parameter int STEP_BITS = 3,
  localparam int IDX_BITS = idx_bits(DIMENSION)
) (
  input  logic                          active,
  input  logic [STEP_BITS-1:0]          step,
  output logic [DIMENSION*IDX_BITS-1:0] feed_idx,
  output logic [DIMENSION-1:0]          feed_valid
);

  logic hit_s;

  // Lane r is valid at step r+k for exactly one k in 0..D-1, and that k is its index.
  always_comb begin
    feed_idx   = '0;
    feed_valid = '0;
    hit_s      = 1'b0;
    for (int r = 0; r < DIMENSION; r++) begin
      for (int k = 0; k < DIMENSION; k++) begin
        hit_s = active && (step == STEP_BITS'(r + k));
        feed_valid[r] = feed_valid[r] | hit_s;
        feed_idx[r*IDX_BITS +: IDX_BITS] = feed_idx[r*IDX_BITS +: IDX_BITS] |
                                           (hit_s ? IDX_BITS'(k) : '0);
      end
    end
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a DIMENSION x DIMENSION systolic array: clear, skewed feed,
// wait for the finish flag (with timeout), then stream result indices out.
module systolic_seq_ctrl
  import systolic_seq_ctrl_pkg::*;
#(
  parameter int DIMENSION    = 4,
  parameter int CLEAR_CYCLES = 2,
  parameter int TIMEOUT      = 64,
  localparam int IDX_BITS    = idx_bits(DIMENSION)
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_start,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_timeout,
  output logic                          o_array_reset,
  output logic [DIMENSION*IDX_BITS-1:0] o_feed_idx,
  output logic [DIMENSION-1:0]          o_feed_valid,
  input  logic                          i_finish,
  output logic [IDX_BITS-1:0]           o_rd_row,
  output logic [IDX_BITS-1:0]           o_rd_col,
  output logic                          o_rd_valid,
  input  logic                          i_rd_ready
);

  localparam int STEP_BITS = $clog2(2*DIMENSION - 1);
  localparam int CLR_BITS  = $clog2(CLEAR_CYCLES + 1);
  localparam int TO_BITS   = $clog2(TIMEOUT + 1);

  localparam logic [STEP_BITS-1:0] STEP_LAST = STEP_BITS'(2*DIMENSION - 2);
  localparam logic [CLR_BITS-1:0]  CLR_LAST  = CLR_BITS'(CLEAR_CYCLES - 1);
  localparam logic [TO_BITS-1:0]   TO_LAST   = TO_BITS'(TIMEOUT - 1);
  localparam logic [IDX_BITS-1:0]  IDX_LAST  = IDX_BITS'(DIMENSION - 1);

  state_t                state_r, state_next_s;
  logic [CLR_BITS-1:0]   clr_cnt_r, clr_next_s;
  logic [STEP_BITS-1:0]  step_r, step_next_s;
  logic [TO_BITS-1:0]    wait_cnt_r, wait_next_s;
  logic [IDX_BITS-1:0]   row_r, row_next_s, col_r, col_next_s;
  logic                  done_s, timeout_s;
  logic                  busy_s, array_reset_s, rd_valid_s, feed_active_s;
  logic [DIMENSION*IDX_BITS-1:0] feed_idx_s, feed_idx_r;
  logic [DIMENSION-1:0]  feed_valid_s, feed_valid_r;
  logic                  busy_r, done_r, timeout_r, array_reset_r, rd_valid_r;

  // State and counter registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r    <= ST_IDLE;
      clr_cnt_r  <= '0;
      step_r     <= '0;
      wait_cnt_r <= '0;
      row_r      <= '0;
      col_r      <= '0;
    end else begin
      state_r    <= state_next_s;
      clr_cnt_r  <= clr_next_s;
      step_r     <= step_next_s;
      wait_cnt_r <= wait_next_s;
      row_r      <= row_next_s;
      col_r      <= col_next_s;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_next_s = state_r;
    clr_next_s   = clr_cnt_r;
    step_next_s  = step_r;
    wait_next_s  = wait_cnt_r;
    row_next_s   = row_r;
    col_next_s   = col_r;
    done_s       = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          state_next_s = ST_CLEAR;
          clr_next_s   = '0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_r == CLR_LAST) begin
          state_next_s = ST_FEED;
          clr_next_s   = '0;
          step_next_s  = '0;
        end else begin
          clr_next_s = clr_cnt_r + CLR_BITS'(1);
        end
      end
      ST_FEED: begin
        if (step_r == STEP_LAST) begin
          state_next_s = ST_WAIT;
          step_next_s  = '0;
          wait_next_s  = '0;
        end else begin
          step_next_s = step_r + STEP_BITS'(1);
        end
      end
      ST_WAIT: begin
        if (i_finish) begin
          state_next_s = ST_READ;
          wait_next_s  = '0;
          row_next_s   = '0;
          col_next_s   = '0;
        end else if (wait_cnt_r == TO_LAST) begin
          state_next_s = ST_IDLE;
          wait_next_s  = '0;
          timeout_s    = 1'b1;
        end else begin
          wait_next_s = wait_cnt_r + TO_BITS'(1);
        end
      end
      ST_READ: begin
        if (rd_valid_r && i_rd_ready) begin
          if (col_r == IDX_LAST) begin
            col_next_s = '0;
            if (row_r == IDX_LAST) begin
              state_next_s = ST_IDLE;
              row_next_s   = '0;
              done_s       = 1'b1;
            end else begin
              row_next_s = row_r + IDX_BITS'(1);
            end
          end else begin
            col_next_s = col_r + IDX_BITS'(1);
          end
        end else begin
          state_next_s = ST_READ;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        clr_next_s   = '0;
        step_next_s  = '0;
        wait_next_s  = '0;
        row_next_s   = '0;
        col_next_s   = '0;
      end
    endcase
  end

  // Outputs decode the upcoming state so the registered copies line up with it.
  always_comb begin
    busy_s        = (state_next_s != ST_IDLE);
    array_reset_s = (state_next_s == ST_CLEAR);
    rd_valid_s    = (state_next_s == ST_READ);
    feed_active_s = (state_next_s == ST_FEED);
  end

  systolic_skew_gen #(
    .DIMENSION (DIMENSION),
    .STEP_BITS (STEP_BITS)
  ) u_skew (
    .active     (feed_active_s),
    .step       (step_next_s),
    .feed_idx   (feed_idx_s),
    .feed_valid (feed_valid_s)
  );

  // Output registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      timeout_r     <= 1'b0;
      array_reset_r <= 1'b0;
      rd_valid_r    <= 1'b0;
      feed_idx_r    <= '0;
      feed_valid_r  <= '0;
    end else begin
      busy_r        <= busy_s;
      done_r        <= done_s;
      timeout_r     <= timeout_s;
      array_reset_r <= array_reset_s;
      rd_valid_r    <= rd_valid_s;
      feed_idx_r    <= feed_idx_s;
      feed_valid_r  <= feed_valid_s;
    end
  end

  assign o_busy        = busy_r;
  assign o_done        = done_r;
  assign o_timeout     = timeout_r;
  assign o_array_reset = array_reset_r;
  assign o_feed_idx    = feed_idx_r;
  assign o_feed_valid  = feed_valid_r;
  assign o_rd_row      = row_r;
  assign o_rd_col      = col_r;
  assign o_rd_valid    = rd_valid_r;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Scoreboard bench for systolic_seq_ctrl: a reference model queues the expected
// feed beats, result beats and end event per run; a monitor pops and compares.
module tb_systolic_seq_ctrl;

  localparam int D  = 4;
  localparam int CC = 2;
  localparam int TO = 64;
  localparam int IB = 2;

  logic clk = 1'b0;
  logic rst_n, start, finish, rd_ready;
  logic busy, done, timeout, array_reset, rd_valid;
  logic [D*IB-1:0] feed_idx;
  logic [D-1:0]    feed_valid;
  logic [IB-1:0]   rd_row, rd_col;

  systolic_seq_ctrl #(.DIMENSION(D), .CLEAR_CYCLES(CC), .TIMEOUT(TO)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_start(start),
    .o_busy(busy), .o_done(done), .o_timeout(timeout), .o_array_reset(array_reset),
    .o_feed_idx(feed_idx), .o_feed_valid(feed_valid), .i_finish(finish),
    .o_rd_row(rd_row), .o_rd_col(rd_col), .o_rd_valid(rd_valid), .i_rd_ready(rd_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [D-1:0] v; logic [D*IB-1:0] idx; } feed_t;

  feed_t         feed_q[$];
  logic [2*IB-1:0] rd_q[$];
  int            end_q[$];   // 1 = done, 2 = timeout
  int            n_cmp = 0;
  int            n_bad = 0;

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic int outs_word();
    return int'({busy, done, timeout, array_reset, feed_idx, feed_valid, rd_row, rd_col, rd_valid});
  endfunction

  // Reference model: lane r sees k-index t-r during steps r..r+D-1; results row-major.
  task automatic push_run(input bit to_timeout);
    feed_t f;
    for (int t = 0; t <= 2*D-2; t++) begin
      f = '0;
      for (int r = 0; r < D; r++) begin
        if (t >= r && t < r + D) begin
          f.v[r] = 1'b1;
          f.idx[r*IB +: IB] = IB'(t - r);
        end
      end
      feed_q.push_back(f);
    end
    if (to_timeout) begin
      end_q.push_back(2);
    end else begin
      for (int row = 0; row < D; row++)
        for (int col = 0; col < D; col++)
          rd_q.push_back({IB'(row), IB'(col)});
      end_q.push_back(1);
    end
  endtask

  feed_t         mf;
  logic [2*IB-1:0] mr;
  int            me;
  int            ar_cnt = 0;

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (feed_valid != '0) begin
        chk("feed_expected", int'(feed_q.size() != 0), 1);
        if (feed_q.size() != 0) begin
          mf = feed_q.pop_front();
          chk("feed_valid", int'(feed_valid), int'(mf.v));
          chk("feed_idx", int'(feed_idx), int'(mf.idx));
        end
      end
      if (rd_valid && rd_ready) begin
        chk("rd_expected", int'(rd_q.size() != 0), 1);
        if (rd_q.size() != 0) begin
          mr = rd_q.pop_front();
          chk("rd_row", int'(rd_row), int'(mr[2*IB-1:IB]));
          chk("rd_col", int'(rd_col), int'(mr[IB-1:0]));
        end
      end
      if (done || timeout) begin
        chk("busy_at_end", int'(busy), 0);
        chk("done_timeout_excl", int'(done & timeout), 0);
        chk("end_expected", int'(end_q.size() != 0), 1);
        if (end_q.size() != 0) begin
          me = end_q.pop_front();
          chk("end_kind", done ? 1 : 2, me);
        end
      end
      if (array_reset) begin
        ar_cnt++;
      end else begin
        if (ar_cnt != 0) chk("clear_len", ar_cnt, CC);
        ar_cnt = 0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Starts a run and steps through clear and feed; returns at the last feed cycle.
  task automatic start_and_feed(input bit noise, output bit ok);
    chk("idle_before_start", int'(busy), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("clear_first", int'(array_reset), 1);
    tick();
    chk("clear_second", int'(array_reset), 1);
    tick();
    chk("clear_over", int'(array_reset), 0);
    chk("feed_t0_valid", int'(feed_valid), 1);
    if (noise) begin
      tick();
      start  = 1'b1;
      finish = 1'b1;
      tick();
      start  = 1'b0;
      finish = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (feed_valid == 4'b1000) ok = 1'b1;
    end
    chk("feed_last_seen", int'(ok), 1);
  endtask

  task automatic run(input int k, input int mode, input bit noise);
    bit ok;
    int beats;
    bit prev_stall;
    logic [IB-1:0] pr, pc;
    push_run(1'b0);
    start_and_feed(noise, ok);
    if (ok) begin
      tick(k);
      chk("no_early_read", int'(rd_valid), 0);
      finish = 1'b1;
      if (k == 0) begin
        tick();
        chk("entry_no_read", int'(rd_valid), 0);
      end
      tick();
      chk("read_latency", int'(rd_valid), 1);
      finish = 1'b0;
      beats = 0;
      prev_stall = 1'b0;
      pr = '0;
      pc = '0;
      for (int c = 0; c < 200 && beats < D*D; c++) begin
        rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((c % 2) == 0) : 1'($urandom_range(0, 1));
        start = (noise && c == 3) ? 1'b1 : 1'b0;
        if (prev_stall) begin
          chk("stall_row", int'(rd_row), int'(pr));
          chk("stall_col", int'(rd_col), int'(pc));
        end
        prev_stall = rd_valid && !rd_ready;
        pr = rd_row;
        pc = rd_col;
        if (rd_valid && rd_ready) beats++;
        tick();
      end
      start = 1'b0;
      chk("beats", beats, D*D);
      chk("done_after_last", int'(done), 1);
      chk("rd_valid_after_last", int'(rd_valid), 0);
      tick();
      chk("done_one_cycle", int'(done), 0);
    end
    rd_ready = 1'b1;
    tick(2);
    chk("feed_q_drained", feed_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    chk("end_q_drained", end_q.size(), 0);
    chk("idle_after_run", int'(busy), 0);
  endtask

  task automatic run_timeout();
    bit ok;
    int n;
    push_run(1'b1);
    start_and_feed(1'b0, ok);
    if (ok) begin
      n = 0;
      for (int i = 0; i < TO + 10 && !timeout; i++) begin
        tick();
        n++;
      end
      chk("timeout_latency", n, TO + 1);
      chk("no_read_on_timeout", int'(rd_valid), 0);
      tick();
      chk("timeout_one_cycle", int'(timeout), 0);
    end
    tick(2);
    chk("to_feed_q_drained", feed_q.size(), 0);
    chk("to_end_q_drained", end_q.size(), 0);
    chk("idle_after_timeout", int'(busy), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    finish   = 1'b0;
    rd_ready = 1'b1;
    tick(2);
    chk("reset_outputs", outs_word(), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", int'(busy), 0);

    // Reset asserted in the middle of feeding.
    push_run(1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(4);
    rst_n = 1'b0;
    #1;
    chk("midfeed_reset_outputs", outs_word(), 0);
    tick(2);
    chk("reset_held_outputs", outs_word(), 0);
    feed_q.delete();
    rd_q.delete();
    end_q.delete();
    rst_n = 1'b1;
    tick();
    chk("release_outputs", outs_word(), 0);
    tick(3);
    chk("release_stays_idle", int'(busy), 0);

    run(10, 0, 1'b0);
    run(3, 1, 1'b1);
    run_timeout();
    run(0, 2, 1'b0);
    for (int i = 0; i < 4; i++)
      run(int'($urandom_range(0, 20)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
